// File: rtl/logic_unit_pipe_pkg.sv
// Opcode constants and shared types for the logic unit; the ALU decoder
// uses the same opcode encoding, so keep the two in step.
package logic_unit_pipe_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_NOT = 3'd2,
    OP_XOR = 3'd3,
    OP_NOR = 3'd4
  } op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic illegal;
  } flags_t;

  localparam int FLAGS_WIDTH = $bits(flags_t);

  function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] code);
    return code <= OP_NOR;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_gates.sv
// Per-function bitwise logic blocks shared across the datapath library.

module logic_and #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

module logic_or #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a | b;
endmodule

module logic_not #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = ~a;
endmodule

module logic_xor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a ^ b;
endmodule

module logic_nor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/logic_unit_pipe_skid.sv
// Two-entry output buffer (main + skid). in_ready comes straight from a flop,
// so there is no combinational path from out_ready back to the producer.
module logic_unit_skid #(
  parameter int WIDTH = 35
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid, main_valid_nxt;
  logic [WIDTH-1:0] main_data, main_data_nxt;
  logic             skid_valid, skid_valid_nxt;
  logic [WIDTH-1:0] skid_data, skid_data_nxt;
  logic             accept, xfer;

  assign accept = in_valid & in_ready;
  assign xfer   = main_valid & out_ready;

  // With skid full, in_ready is already low, so a transfer never races an accept.
  always_comb begin
    main_valid_nxt = main_valid;
    main_data_nxt  = main_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (xfer) begin
      if (skid_valid) begin
        main_data_nxt  = skid_data;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        main_data_nxt = in_data;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = in_data;
      end else begin
        main_valid_nxt = 1'b1;
        main_data_nxt  = in_data;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      main_data  <= main_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      in_ready   <= ~skid_valid_nxt;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshakes on both sides,
// result flags, illegal-opcode detection and a saturating request counter.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  op_count
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + FLAGS_WIDTH;

  logic [DATA_WIDTH-1:0]  and_y, or_y, not_y, xor_y, nor_y;
  logic [DATA_WIDTH-1:0]  calc_result;
  flags_t                 calc_flags;
  logic [ENTRY_WIDTH-1:0] in_entry, out_entry;
  flags_t                 out_flags;
  logic                   accept;

  logic_and #(.WIDTH(DATA_WIDTH)) u_and (.a(A), .b(B), .y(and_y));
  logic_or  #(.WIDTH(DATA_WIDTH)) u_or  (.a(A), .b(B), .y(or_y));
  logic_not #(.WIDTH(DATA_WIDTH)) u_not (.a(A),        .y(not_y));
  logic_xor #(.WIDTH(DATA_WIDTH)) u_xor (.a(A), .b(B), .y(xor_y));
  logic_nor #(.WIDTH(DATA_WIDTH)) u_nor (.a(A), .b(B), .y(nor_y));

  // Illegal opcodes yield a zero result, which makes the zero flag fall out naturally.
  always_comb begin
    calc_result = '0;
    case (op)
      OP_AND:  calc_result = and_y;
      OP_OR:   calc_result = or_y;
      OP_NOT:  calc_result = not_y;
      OP_XOR:  calc_result = xor_y;
      OP_NOR:  calc_result = nor_y;
      default: calc_result = '0;
    endcase
    calc_flags.zero    = (calc_result == '0);
    calc_flags.neg     = calc_result[DATA_WIDTH-1];
    calc_flags.illegal = ~op_is_legal(op);
  end

  assign in_entry = {calc_result, calc_flags};

  logic_unit_skid #(.WIDTH(ENTRY_WIDTH)) u_skid (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign result    = out_entry[ENTRY_WIDTH-1:FLAGS_WIDTH];
  assign out_flags = flags_t'(out_entry[FLAGS_WIDTH-1:0]);
  assign flag_z    = out_flags.zero;
  assign flag_n    = out_flags.neg;
  assign illegal   = out_flags.illegal;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      op_count <= '0;
    end else if (accept && (op_count != '1)) begin
      op_count <= op_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (8-bit counter to reach saturation).
module tb_logic_unit_pipe;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_z, flag_n, illegal;
  logic [7:0]  op_count;

  int total = 0;
  int bad   = 0;

  logic_unit_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .illegal   (illegal),
    .op_count  (op_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic rdy);
    in_valid  = v;
    op        = o;
    A         = a;
    B         = b;
    out_ready = rdy;
  endtask

  initial begin
    clear_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result",    result,         32'd0);
    checkOutput("rst_flags",     32'({flag_z, flag_n, illegal}), 32'd0);
    checkOutput("rst_count",     32'(op_count),  32'd0);
    clear_n = 1'b1;
    @(negedge clock);
    checkOutput("rel_in_ready",  32'(in_ready),  32'd1);

    // Streaming legal and illegal ops with out_ready held high
    applyStimulus(1'b1, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
    @(negedge clock);
    checkOutput("and_valid",  32'(out_valid), 32'd1);
    checkOutput("and_result", result,         32'hF000F000);
    checkOutput("and_n",      32'(flag_n),    32'd1);
    checkOutput("and_z",      32'(flag_z),    32'd0);
    checkOutput("and_ill",    32'(illegal),   32'd0);
    checkOutput("and_count",  32'(op_count),  32'd1);
    applyStimulus(1'b1, 3'd4, 32'hFFFFFFFF, 32'h0, 1'b1);
    @(negedge clock);
    checkOutput("nor_result", result,        32'h0);
    checkOutput("nor_z",      32'(flag_z),   32'd1);
    checkOutput("nor_n",      32'(flag_n),   32'd0);
    applyStimulus(1'b1, 3'd2, 32'h0, 32'h12345678, 1'b1);
    @(negedge clock);
    checkOutput("not_result", result,        32'hFFFFFFFF);
    checkOutput("not_n",      32'(flag_n),   32'd1);
    checkOutput("not_z",      32'(flag_z),   32'd0);
    applyStimulus(1'b1, 3'd6, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
    @(negedge clock);
    checkOutput("ill_flag",   32'(illegal),  32'd1);
    checkOutput("ill_result", result,        32'h0);
    checkOutput("ill_z",      32'(flag_z),   32'd1);
    checkOutput("ill_n",      32'(flag_n),   32'd0);
    checkOutput("ill_count",  32'(op_count), 32'd4);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    @(negedge clock);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: fill main and skid, hold a third request, then release
    applyStimulus(1'b1, 3'd1, 32'h1, 32'h2, 1'b0);
    @(negedge clock);
    checkOutput("bp1_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 3'd3, 32'hFF, 32'h0F, 1'b0);
    @(negedge clock);
    checkOutput("bp2_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp2_result",   result,        32'h3);
    applyStimulus(1'b1, 3'd0, 32'hFFFF, 32'h00FF, 1'b0);
    @(negedge clock);
    checkOutput("bp3_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp3_hold",     result,        32'h3);
    checkOutput("bp3_valid",    32'(out_valid), 32'd1);
    checkOutput("bp3_count",    32'(op_count), 32'd6);
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("bp_second",    result,        32'hF0);
    checkOutput("bp_ready_up",  32'(in_ready), 32'd1);
    @(negedge clock);
    checkOutput("bp_third",     result,        32'hFF);
    checkOutput("bp_count",     32'(op_count), 32'd7);
    in_valid = 1'b0;
    @(negedge clock);
    checkOutput("bp_empty",     32'(out_valid), 32'd0);

    // Full-rate stream: one result per cycle, counter saturates
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 3'd3, 32'(i), 32'h55555555, 1'b1);
      @(negedge clock);
      checkOutput("rate_valid",  32'(out_valid), 32'd1);
      checkOutput("rate_result", result,         32'(i) ^ 32'h55555555);
    end
    checkOutput("sat_count", 32'(op_count), 32'd255);
    in_valid = 1'b0;
    @(negedge clock);

    // Asynchronous reset with both entries full
    applyStimulus(1'b1, 3'd1, 32'hA0, 32'h0B, 1'b0);
    @(negedge clock);
    applyStimulus(1'b1, 3'd1, 32'hC0, 32'h0D, 1'b0);
    @(negedge clock);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2;
    clear_n = 1'b0;
    #1;
    checkOutput("arst_valid",    32'(out_valid), 32'd0);
    checkOutput("arst_count",    32'(op_count),  32'd0);
    checkOutput("arst_in_ready", 32'(in_ready),  32'd0);
    checkOutput("arst_result",   result,         32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    checkOutput("post_in_ready", 32'(in_ready),  32'd1);
    checkOutput("post_valid",    32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, transaction-counter width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clear_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port op  input  3  operation code: 0 AND, 1 OR, 2 NOT(A), 3 XOR, 4 NOR, 5-7 illegal.
REQ-008 SHALL have port A  input  DATA_WIDTH  first operand.
REQ-009 SHALL have port B  input  DATA_WIDTH  second operand; ignored for NOT.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-012 SHALL have port result  output  DATA_WIDTH  operation result.
REQ-013 SHALL have port flag_z  output  1  result equals zero.
REQ-014 SHALL have port flag_n  output  1  result MSB.
REQ-015 SHALL have port illegal  output  1  op was 5-7.
REQ-016 SHALL have port op_count  output  CNT_WIDTH  accepted-request count, saturating.

Function
REQ-017 SHALL accept a request on a cycle where in_valid and in_ready are both 1 (input handshake).
REQ-018 SHALL transfer a result on a cycle where out_valid and out_ready are both 1 (output handshake).
REQ-019 SHALL compute result combinationally from op/A/B at acceptance and register it with flags; latency from accept to out_valid is exactly 1 cycle.
REQ-020 SHALL, for illegal op, register result 0, flag_z 1, flag_n 0, illegal 1; legal ops register illegal 0.
REQ-021 SHALL buffer two entries: a main output register plus a skid register, so in_ready is a registered signal with no combinational path from out_ready.
REQ-022 SHALL drive in_ready 1 when the skid register is empty.
REQ-023 SHALL move an accepted result into the skid register when the main register holds an untransferred result; on a later transfer, skid contents move to main in the same edge.
REQ-024 SHALL, in the cycle after a main-register transfer with both registers empty and no new accept, drive out_valid 0.
REQ-025 SHALL support simultaneous accept and transfer at full rate: one result per cycle with out_ready held 1.
REQ-026 SHALL keep result, flags and illegal stable while out_valid is 1 and out_ready is 0.
REQ-027 SHALL present results in acceptance order; no request dropped or duplicated.
REQ-028 SHALL increment op_count by 1 per accepted request, legal or illegal, saturating at all-ones.

Reset
REQ-029 SHALL, on clear_n low, asynchronously force out_valid 0, both buffer entries empty, result 0, flag_z 0, flag_n 0, illegal 0, op_count 0; in_ready SHALL be 0 while clear_n is low.
REQ-030 SHALL drive in_ready 1 on the first rising clock edge after clear_n deasserts; reset mid-operation discards all buffered results.

Structure
REQ-031 SHALL take opcode constants (OP_AND..OP_NOR) and opcode width from a shared ALU package used by the ALU decoder.
REQ-032 SHALL instantiate the existing per-function logic modules (AND, OR, NOT, XOR, NOR) for datapath evaluation; one sub-module, logic_unit_skid (two-entry buffer), SHALL hold all handshake state.

Verification
REQ-033 SHALL check: op=0, A=0xF0F0F0F0, B=0xFF00FF00, out_ready=1 -> next cycle result 0xF000F000, flag_n 1, flag_z 0.
REQ-034 SHALL check: op=4, A=0xFFFFFFFF, B=0 -> result 0, flag_z 1; op=2, A=0 -> result 0xFFFFFFFF, flag_n 1.
REQ-035 SHALL check: op=6 -> illegal 1, result 0, flag_z 1; op_count increments.
REQ-036 SHALL check: out_ready=0, two back-to-back requests -> in_ready drops to 0 after the second; third held; release out_ready -> three results in order, none lost.
REQ-037 SHALL check: 300 continuous requests with out_ready=1 -> one result per cycle; CNT_WIDTH=8 -> op_count saturates at 255.
REQ-038 SHALL check: clear_n pulsed low with both entries full -> out_valid 0 immediately, op_count 0, in_ready 1 one edge after release.
